// File: rtl/bpm_window_ctrl.sv
// Heart-rate measurement window controller: ms prescaler, fixed-length counting
// window, synchronized beat counting and saturating beats-per-minute conversion.
module bpm_window_ctrl #(
    parameter int TICK_DIV  = 100_000,
    parameter int WINDOW_MS = 15_000,
    parameter int BPM_MULT  = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             beat_in,
    output logic             busy,
    output logic [CNT_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             overflow,
    output logic             heartbeat_led
);
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MS_W   = (WINDOW_MS > 1) ? $clog2(WINDOW_MS) : 1;
    localparam int PROD_W = CNT_W + $clog2(BPM_MULT) + 1;

    localparam logic [PRE_W-1:0]          PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]           MS_LAST  = MS_W'(WINDOW_MS - 1);
    localparam logic [CNT_W-1:0]          CNT_MAX  = '1;
    localparam logic signed [PROD_W-1:0]  MULT_S   = PROD_W'(BPM_MULT);
    localparam logic signed [PROD_W-1:0]  BPM_MAX  = PROD_W'((1 << CNT_W) - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LATCH} state_t;

    state_t                    state, state_nxt;
    logic                      beat_sync_p0, beat_sync_p1, beat_prev_p2;
    logic                      beat_evt, tick, win_end;
    logic                      clr_all, do_latch, sat_hit;
    logic [PRE_W-1:0]          presc;
    logic [MS_W-1:0]           ms_cnt;
    logic [CNT_W-1:0]          beat_cnt;
    logic signed [PROD_W-1:0]  product;

    function automatic logic signed [PROD_W-1:0] scale_cnt(input logic [CNT_W-1:0] cnt);
        return $signed({{(PROD_W-CNT_W){1'b0}}, cnt}) * MULT_S;
    endfunction

    function automatic logic [CNT_W-1:0] sat_bpm(input logic signed [PROD_W-1:0] p);
        return (p > BPM_MAX) ? CNT_MAX : p[CNT_W-1:0];
    endfunction

    assign busy     = (state != IDLE);
    assign beat_evt = beat_sync_p1 & ~beat_prev_p2;
    assign tick     = (state == MEASURE) && (presc == PRE_LAST);
    assign win_end  = tick && (ms_cnt == MS_LAST);
    assign product  = scale_cnt(beat_cnt);
    assign sat_hit  = (product > BPM_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // stop overrides everything; start overrides a pending window end or latch
    always_comb begin
        state_nxt = state;
        clr_all   = 1'b0;
        do_latch  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MEASURE;
                    clr_all   = 1'b1;
                end
            end
            MEASURE: begin
                if (start)        clr_all   = 1'b1;
                else if (win_end) state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = MEASURE;
                if (start) clr_all  = 1'b1;
                else       do_latch = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            clr_all   = 1'b0;
            do_latch  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_sync_p0  <= 1'b0;
            beat_sync_p1  <= 1'b0;
            beat_prev_p2  <= 1'b0;
            presc         <= '0;
            ms_cnt        <= '0;
            beat_cnt      <= '0;
            bpm           <= '0;
            bpm_valid     <= 1'b0;
            overflow      <= 1'b0;
            heartbeat_led <= 1'b0;
        end else begin
            // p0/p1: synchronizer, p2: previous level for edge detect
            beat_sync_p0 <= beat_in;
            beat_sync_p1 <= beat_sync_p0;
            beat_prev_p2 <= beat_sync_p1;
            bpm_valid    <= 1'b0;

            if (clr_all || stop || state != MEASURE) begin
                presc  <= '0;
                ms_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) ms_cnt <= win_end ? '0 : ms_cnt + 1'b1;
            end

            if (clr_all || stop) begin
                beat_cnt <= '0;
            end else if (do_latch) begin
                beat_cnt <= beat_evt ? CNT_W'(1) : '0;
            end else if (state == MEASURE && beat_evt && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (clr_all) begin
                overflow <= 1'b0;
            end else if (do_latch) begin
                bpm           <= sat_bpm(product);
                bpm_valid     <= 1'b1;
                heartbeat_led <= ~heartbeat_led;
                if (sat_hit) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bpm_window_ctrl.sv
// Directed bench for bpm_window_ctrl: 40-cycle windows on the main instance and
// 640-cycle windows on a second instance used for the saturation case.
module tb_bpm_window_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       beat_in = 1'b0;
    logic       busy, bpm_valid, overflow, heartbeat_led;
    logic [7:0] bpm;
    logic       busy_s, bpm_valid_s, overflow_s, heartbeat_led_s;
    logic [7:0] bpm_s;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int rel = 0;
    int led_chg = 0;
    logic led_prev = 1'b0;
    int beat_at[$];
    int beat_hi = 2;
    int v_at[$];
    int v_bpm[$];

    bpm_window_ctrl #(.TICK_DIV(4), .WINDOW_MS(10), .BPM_MULT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .beat_in(beat_in),
        .busy(busy), .bpm(bpm), .bpm_valid(bpm_valid), .overflow(overflow),
        .heartbeat_led(heartbeat_led)
    );

    bpm_window_ctrl #(.TICK_DIV(64), .WINDOW_MS(10), .BPM_MULT(4), .CNT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .beat_in(beat_in),
        .busy(busy_s), .bpm(bpm_s), .bpm_valid(bpm_valid_s), .overflow(overflow_s),
        .heartbeat_led(heartbeat_led_s)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic beat_level(input int r);
        foreach (beat_at[i])
            if (r >= beat_at[i] && r < beat_at[i] + beat_hi) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - t0;
        beat_in = beat_level(rel);
        if (bpm_valid) begin
            v_at.push_back(rel);
            v_bpm.push_back(int'(bpm));
        end
        if (heartbeat_led != led_prev) led_chg++;
        led_prev = heartbeat_led;
    endtask

    task automatic run_to(input int target);
        while (rel < target) step();
    endtask

    task automatic new_phase();
        t0 = cyc;
        rel = 0;
        v_at.delete();
        v_bpm.delete();
        led_chg = 0;
        led_prev = heartbeat_led;
    endtask

    task automatic pulse_start();
        new_phase();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_bpm", int'(bpm), 0);
        check_val("rst_valid", int'(bpm_valid), 0);
        check_val("rst_ovf", int'(overflow), 0);
        check_val("rst_led", int'(heartbeat_led), 0);

        new_phase();
        run_to(100);
        check_val("idle_strobes", v_at.size(), 0);
        check_val("idle_led_chg", led_chg, 0);
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_bpm", int'(bpm), 0);

        // nominal: 5 beats then an empty window
        beat_at = '{2, 8, 14, 20, 26};
        beat_hi = 3;
        pulse_start();
        check_val("nom_busy", int'(busy), 1);
        run_to(45);
        check_val("nom_n1", v_at.size(), 1);
        if (v_at.size() == 1) begin
            check_val("nom_at1", v_at[0], 42);
            check_val("nom_bpm1", v_bpm[0], 20);
        end
        check_val("nom_led1", int'(heartbeat_led), 1);
        check_val("nom_ovf", int'(overflow), 0);
        v_at.delete();
        v_bpm.delete();
        run_to(86);
        check_val("nom_n2", v_at.size(), 1);
        if (v_at.size() == 1) begin
            check_val("nom_at2", v_at[0], 83);
            check_val("nom_bpm2", v_bpm[0], 0);
        end
        check_val("nom_led2", int'(heartbeat_led), 0);

        // boundary: edge on win_end (cycle 40) and on LATCH (cycle 82)
        beat_at = '{10, 38, 80};
        beat_hi = 2;
        pulse_start();
        run_to(126);
        check_val("bnd_n", v_at.size(), 3);
        if (v_at.size() == 3) begin
            check_val("bnd_at0", v_at[0], 42);
            check_val("bnd_bpm0", v_bpm[0], 8);
            check_val("bnd_at1", v_at[1], 83);
            check_val("bnd_bpm1", v_bpm[1], 0);
            check_val("bnd_at2", v_at[2], 124);
            check_val("bnd_bpm2", v_bpm[2], 4);
        end

        // stop mid-window
        beat_at.delete();
        pulse_start();
        run_to(20);
        check_val("stop_busy20", int'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("stop_busy21", int'(busy), 0);
        run_to(60);
        check_val("stop_strobes", v_at.size(), 0);
        check_val("stop_bpm", int'(bpm), 4);

        // start and stop together while idle
        new_phase();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check_val("prio_busy", int'(busy), 0);
        run_to(50);
        check_val("prio_strobes", v_at.size(), 0);
        check_val("prio_busy_end", int'(busy), 0);

        // restart at cycle 30 discards the early beat
        beat_at = '{5, 40, 50};
        beat_hi = 3;
        pulse_start();
        run_to(30);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(76);
        check_val("rst30_n", v_at.size(), 1);
        if (v_at.size() == 1) begin
            check_val("rst30_at", v_at[0], 72);
            check_val("rst30_bpm", v_bpm[0], 8);
        end

        // asynchronous reset between edges
        beat_at.delete();
        pulse_start();
        run_to(25);
        check_val("arst_bpm_pre", int'(bpm), 8);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_busy", int'(busy), 0);
        check_val("arst_bpm", int'(bpm), 0);
        check_val("arst_valid", int'(bpm_valid), 0);
        check_val("arst_led", int'(heartbeat_led), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        new_phase();
        run_to(100);
        check_val("arst_strobes", v_at.size(), 0);
        check_val("arst_busy_end", int'(busy), 0);

        // saturation on the 640-cycle instance: 70 beats -> 280 clipped to 255
        beat_at.delete();
        for (int k = 0; k < 70; k++) beat_at.push_back(4 + 4 * k);
        beat_hi = 2;
        pulse_start();
        run_to(641);
        check_val("sat_valid641", int'(bpm_valid_s), 0);
        step();
        check_val("sat_valid642", int'(bpm_valid_s), 1);
        check_val("sat_bpm", int'(bpm_s), 255);
        check_val("sat_ovf", int'(overflow_s), 1);
        run_to(700);
        check_val("sat_ovf_hold", int'(overflow_s), 1);
        check_val("sat_busy", int'(busy_s), 1);
        beat_at.delete();
        pulse_start();
        check_val("sat_ovf_clr", int'(overflow_s), 0);
        check_val("sat_bpm_keep", int'(bpm_s), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bpm_window_ctrl.md
# bpm_window_ctrl

Measurement-window controller for the heart-rate datapath. Sequences a programmable prescaler into a millisecond tick, gates a fixed-length counting window, counts synchronized beat edges and converts the count to beats-per-minute at each window end. Runs continuously between `start` and `stop`. Replaces the free-running toggle divider as the timebase source for the BPM display path.

## Interface
- `TICK_DIV`, 100_000: `clk` cycles per ms tick (100 MHz → 1 kHz).
- `WINDOW_MS`, 15_000: window length in ticks.
- `BPM_MULT`, 4: window-to-minute scale; 60 s / 15 s.
- `CNT_W`, 8: width of the beat counter and `bpm`.

- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle pulse; begins or restarts measurement.
- `stop`, in, 1: single-cycle pulse; aborts measurement and returns to idle.
- `beat_in`, in, 1: asynchronous beat pulse from the sensor front end.
- `busy`, out, 1: high while not IDLE.
- `bpm`, out, CNT_W: last completed result; held between windows.
- `bpm_valid`, out, 1: one-cycle strobe when `bpm` updates.
- `overflow`, out, 1: sticky; set when a result saturated; cleared by `start`.
- `heartbeat_led`, out, 1: toggles at each window end.

## Operation
- `beat_in` passes through a 2-FF synchronizer, then a rising-edge detector. The edge pulse is `beat_evt`.
- Prescaler counts 0..TICK_DIV-1 only in MEASURE. It raises `tick` at the terminal value. Held at 0 in IDLE and LATCH.
- ms counter counts ticks 0..WINDOW_MS-1. `win_end` = `tick` while ms count == WINDOW_MS-1.
- Beat counter is CNT_W wide, increments on `beat_evt`, and saturates at 2^CNT_W-1.
- FSM:
  - IDLE: `start` → MEASURE. All counters are cleared and `overflow` is cleared.
  - MEASURE: `win_end` → LATCH. A further `start` restarts the window: counters are cleared and the state stays MEASURE.
  - LATCH, one cycle: product = beat count × BPM_MULT, computed at CNT_W+clog2(BPM_MULT)+1 bits. `bpm` = min(product, 2^CNT_W-1). Saturation sets `overflow`. Pulse `bpm_valid`, toggle `heartbeat_led`, clear prescaler and ms counter. Go to MEASURE.
  - Any state: `stop` → IDLE. No `bpm_valid` is produced and `bpm` is retained.
- Simultaneous events:
  - `stop` and `start` in the same cycle: `stop` wins.
  - `beat_evt` in the `win_end` cycle: counted in the ending window.
  - `beat_evt` during LATCH: the counter loads 1 for the new window, otherwise 0.
  - `start` in the `win_end` cycle: restart wins; no LATCH and no result.
- `rst` clears everything immediately, at any time, including the synchronizer flops.

## Timing
- Reset values: `busy`=0, `bpm`=0, `bpm_valid`=0, `overflow`=0, `heartbeat_led`=0. FSM resets to IDLE.
- `start` is sampled at edge E0. `busy`=1 from E0. The prescaler begins counting in the cycle after E0.
- Window = TICK_DIV×WINDOW_MS cycles. With `win_end` in cycle N, LATCH is in N+1. `bpm` and `bpm_valid` are visible in N+2, and `bpm_valid` is high only in N+2.
- Consecutive windows are TICK_DIV×WINDOW_MS+1 cycles apart, the extra cycle being LATCH.
- Beat latency: a `beat_in` rising edge is counted 3 clocks later.
- `beat_in` pulses must stay high ≥2 clk cycles and low ≥2 cycles to be detected.

## Test plan
Bench parameters: TICK_DIV=4, WINDOW_MS=10, BPM_MULT=4, CNT_W=8, giving a 40-cycle window.
- Reset and idle: assert `rst` for 3 cycles, hold 100 cycles with no `start` → all outputs 0, no `bpm_valid`, `heartbeat_led` static.
- Nominal: `start` at cycle 0, 5 beats (3 high / 3 low) well inside the window → `bpm`=20 with `bpm_valid` at cycle 42 only. `heartbeat_led`=1. A second window with 0 beats → `bpm`=0 with the strobe at cycle 83.
- Saturation: 70 beats in one window (requires TICK_DIV raised to 64) → `bpm`=255, `overflow`=1. `overflow` stays 1 into the next window and clears on the next `start`.
- Boundary beat: align `beat_evt` to the `win_end` cycle → counted in the old window (+4 bpm). Align a second edge to the LATCH cycle → next window's result includes it.
- Abort and priority:
  - `stop` at cycle 20 → `busy`=0 at cycle 21, no strobe, `bpm` unchanged.
  - `start`+`stop` in the same cycle while idle → stays idle.
  - `start` at cycle 30 of a window → window restarts, strobe at cycle 72.
- Async reset mid-window: assert `rst` between clock edges at cycle 25 → outputs 0 immediately. After release there is no strobe until a new `start`.
